// File: rtl/adf4360_pkg.sv
// Shared definitions for the ADF4360 3-wire programming interface (master and receiver).
package adf4360_pkg;

  localparam int unsigned ADF_WORD_BITS = 24;

  localparam logic [1:0] ADDR_CTRL = 2'b00;
  localparam logic [1:0] ADDR_R    = 2'b01;
  localparam logic [1:0] ADDR_N    = 2'b10;
  localparam logic [1:0] ADDR_RSVD = 2'b11;

  typedef enum logic [1:0] {
    EXP_R,
    EXP_C,
    EXP_N,
    DONE
  } order_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus a rising-edge detector.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/adf4360_serial_rx.sv
// ADF4360 3-wire receiver: deserialises MSB-first words, stores R/C/N latch images and
// flags length, reserved-address and initialisation-order errors.
module adf4360_serial_rx
  import adf4360_pkg::*;
#(
  parameter int unsigned WORD_BITS   = ADF_WORD_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sdata_i,
  input  logic                 sclk_i,
  input  logic                 le_i,
  input  logic                 clr_i,
  output logic [WORD_BITS-1:0] r_o,
  output logic [WORD_BITS-1:0] c_o,
  output logic [WORD_BITS-1:0] n_o,
  output logic                 word_valid_o,
  output logic [1:0]           word_addr_o,
  output logic                 prog_done_o,
  output logic                 err_len_o,
  output logic                 err_addr_o,
  output logic                 err_order_o
);

  localparam logic [4:0] CntFull = 5'(WORD_BITS);
  localparam logic [4:0] CntMax  = 5'd31;

  logic sdata_lvl, sdata_rise_unused;
  logic sclk_lvl, sclk_rise;
  logic le_lvl, le_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (sdata_i),
    .level_o(sdata_lvl),
    .rise_o (sdata_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (sclk_i),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (le_i),
    .level_o(le_lvl),
    .rise_o (le_rise)
  );

  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [WORD_BITS-1:0] r_q, c_q, n_q;
  logic                 word_valid_q;
  logic [1:0]           word_addr_q;
  logic                 err_len_q, err_addr_q, err_order_q;
  order_state_e         state_q, state_d;

  logic [1:0] addr;
  logic       full_word, accept, addr_bad, len_bad, order_bad;

  assign addr      = shift_q[1:0];
  assign full_word = (cnt_q == CntFull);
  assign accept    = le_rise && full_word && (addr != ADDR_RSVD);
  assign addr_bad  = le_rise && full_word && (addr == ADDR_RSVD);
  assign len_bad   = le_rise && !full_word;

  // An le edge always clears the shifter, so a coincident sclk edge is dropped.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (le_rise) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise && !le_lvl) begin
      shift_d = {shift_q[WORD_BITS-2:0], sdata_lvl};
      if (cnt_q != CntMax) cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EXP_R;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    order_bad = 1'b0;
    if (accept) begin
      unique case (state_q)
        EXP_R: begin
          if (addr == ADDR_R) state_d = EXP_C;
          else                order_bad = 1'b1;
        end
        EXP_C: begin
          if (addr == ADDR_CTRL)   state_d = EXP_N;
          else if (addr == ADDR_N) order_bad = 1'b1;
        end
        EXP_N: begin
          if (addr == ADDR_N)      state_d = DONE;
          else if (addr == ADDR_R) state_d = EXP_C;
        end
        DONE:    state_d = DONE;
        default: state_d = EXP_R;
      endcase
    end
    if (clr_i) state_d = EXP_R;
  end

  always_comb begin
    prog_done_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      r_q          <= '0;
      c_q          <= '0;
      n_q          <= '0;
      word_valid_q <= 1'b0;
      word_addr_q  <= '0;
      err_len_q    <= 1'b0;
      err_addr_q   <= 1'b0;
      err_order_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_valid_q <= accept;
      if (accept) begin
        word_addr_q <= addr;
        if (addr == ADDR_CTRL) c_q <= shift_q;
        if (addr == ADDR_R)    r_q <= shift_q;
        if (addr == ADDR_N)    n_q <= shift_q;
      end
      // A set on the same cycle as clr_i takes priority.
      err_len_q   <= len_bad   | (err_len_q   & ~clr_i);
      err_addr_q  <= addr_bad  | (err_addr_q  & ~clr_i);
      err_order_q <= order_bad | (err_order_q & ~clr_i);
    end
  end

  assign r_o          = r_q;
  assign c_o          = c_q;
  assign n_o          = n_q;
  assign word_valid_o = word_valid_q;
  assign word_addr_o  = word_addr_q;
  assign err_len_o    = err_len_q;
  assign err_addr_o   = err_addr_q;
  assign err_order_o  = err_order_q;

endmodule

// File: tb/tb_adf4360_serial_rx.sv
// Directed bench for adf4360_serial_rx with a scoreboard of expected accepted words.
module tb_adf4360_serial_rx;

  logic        clk = 1'b0;
  logic        rst, sdata, sclk, le, clr;
  logic [23:0] r_o, c_o, n_o;
  logic        word_valid, prog_done, err_len, err_addr, err_order;
  logic [1:0]  word_addr;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  adf4360_serial_rx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sdata_i     (sdata),
    .sclk_i      (sclk),
    .le_i        (le),
    .clr_i       (clr),
    .r_o         (r_o),
    .c_o         (c_o),
    .n_o         (n_o),
    .word_valid_o(word_valid),
    .word_addr_o (word_addr),
    .prog_done_o (prog_done),
    .err_len_o   (err_len),
    .err_addr_o  (err_addr),
    .err_order_o (err_order)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: each word_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && word_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("word_addr", {30'd0, word_addr}, {30'd0, e[1:0]});
        case (e[1:0])
          2'b00:   check("pulse_c", {8'd0, c_o}, {8'd0, e});
          2'b01:   check("pulse_r", {8'd0, r_o}, {8'd0, e});
          default: check("pulse_n", {8'd0, n_o}, {8'd0, e});
        endcase
      end
    end
  end

  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sdata = w[23-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_le();
    repeat (4) @(negedge clk);
    le = 1'b1;
    repeat (4) @(negedge clk);
    le = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input bit expect_pulse);
    if (expect_pulse) exp_q.push_back(w);
    send_bits(w, 24);
    pulse_le();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_errs(input string tag, input logic [2:0] expv);
    check(tag, {29'd0, err_len, err_addr, err_order}, {29'd0, expv});
  endtask

  initial begin
    rst = 1'b1; sdata = 1'b0; sclk = 1'b0; le = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_r", {8'd0, r_o}, 32'd0);
    check("reset_c", {8'd0, c_o}, 32'd0);
    check("reset_n", {8'd0, n_o}, 32'd0);
    check("reset_flags", {27'd0, word_valid, prog_done, err_len, err_addr, err_order}, 32'd0);
    check("reset_addr", {30'd0, word_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal R, C, N sequence
    send_word(24'h123455, 1'b1);
    check("prog_after_r", {31'd0, prog_done}, 32'd0);
    send_word(24'h234564, 1'b1);
    send_word(24'h34567A, 1'b1);
    check("nom_r", {8'd0, r_o}, 32'h123455);
    check("nom_c", {8'd0, c_o}, 32'h234564);
    check("nom_n", {8'd0, n_o}, 32'h34567A);
    check("nom_done", {31'd0, prog_done}, 32'd1);
    check_errs("nom_errs", 3'b000);

    // Short word, then a correct R word
    send_bits(24'hFFFFFD, 23);
    pulse_le();
    check_errs("short_errs", 3'b100);
    check("short_r_kept", {8'd0, r_o}, 32'h123455);
    send_word(24'h111111, 1'b1);
    check("after_short_r", {8'd0, r_o}, 32'h111111);
    check("after_short_done", {31'd0, prog_done}, 32'd1);

    // Reserved address
    send_word(24'hABCDE7, 1'b0);
    check_errs("rsvd_errs", 3'b110);
    check("rsvd_c_kept", {8'd0, c_o}, 32'h234564);

    pulse_clr();
    check_errs("clr_errs", 3'b000);
    check("clr_done", {31'd0, prog_done}, 32'd0);
    check("clr_r_kept", {8'd0, r_o}, 32'h111111);

    // Order violation: N first is still written
    send_word(24'h345672, 1'b1);
    check("order_n", {8'd0, n_o}, 32'h345672);
    check_errs("order_errs", 3'b001);
    check("order_done", {31'd0, prog_done}, 32'd0);
    pulse_clr();
    send_word(24'h123455, 1'b1);
    send_word(24'h234564, 1'b1);
    send_word(24'h34567A, 1'b1);
    check("reinit_done", {31'd0, prog_done}, 32'd1);
    check_errs("reinit_errs", 3'b000);
    check("reinit_n", {8'd0, n_o}, 32'h34567A);

    // Collision: 25th sclk edge together with le rise
    pulse_clr();
    exp_q.push_back(24'h5A5A5D);
    send_bits(24'h5A5A5D, 24);
    repeat (4) @(negedge clk);
    sdata = 1'b1;
    sclk  = 1'b1;
    le    = 1'b1;
    repeat (4) @(negedge clk);
    // sclk toggling while le is high must not count
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    le = 1'b0;
    repeat (4) @(negedge clk);
    check("coll_r", {8'd0, r_o}, 32'h5A5A5D);
    check_errs("coll_errs", 3'b000);
    send_word(24'h0F0F0D, 1'b1);
    check("le_high_r", {8'd0, r_o}, 32'h0F0F0D);
    check_errs("le_high_errs", 3'b000);

    // Reset mid-word
    send_bits(24'hFEDCBA, 12);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_r", {8'd0, r_o}, 32'd0);
    check("rst_mid_n", {8'd0, n_o}, 32'd0);
    check("rst_mid_flags", {27'd0, word_valid, prog_done, err_len, err_addr, err_order}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_word(24'h765431, 1'b1);
    check("rst_mid_new_r", {8'd0, r_o}, 32'h765431);
    check_errs("rst_mid_errs", 3'b000);
    check("rst_mid_c", {8'd0, c_o}, 32'd0);

    // Le with no shifts after reset counts as a length error
    pulse_le();
    check_errs("empty_le_errs", 3'b100);

    repeat (10) @(negedge clk);
    check("pending_words", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
